// File: rtl/prop_delay_bist_pkg.sv
// Shared types and the golden reference for the D = ~(A&B) | C, E = A&B gate BIST.
package prop_delay_bist_pkg;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_e;

  // Returns {exp_d, exp_e} for stimulus vec = {A, B, C}.
  function automatic logic [1:0] golden_de(input vec_t vec);
    logic ab;
    ab = vec[2] & vec[1];
    return {~ab | vec[0], ab};
  endfunction

endpackage

// File: rtl/prop_delay_bist_if.sv
// Stimulus/response bus between the BIST engine (master) and the circuit under test (slave).
interface prop_delay_bist_if;
  logic a_out;
  logic b_out;
  logic c_out;
  logic d_in;
  logic e_in;

  modport master (output a_out, b_out, c_out, input d_in, e_in);
  modport slave  (input a_out, b_out, c_out, output d_in, e_in);
endinterface

// File: rtl/bist_settle_timer.sv
// Loadable down-counter with a zero flag; holds at zero and when not enabled.
module bist_settle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/prop_delay_bist_checker.sv
// Propagation-delay BIST: sweeps all 8 A/B/C vectors, samples D/E after a settle window.
// Optional first-failure capture is enabled by defining BIST_FAIL_CAPTURE_EN.
module prop_delay_bist_checker
  import prop_delay_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  prop_delay_bist_if.master        cut,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [VEC_W-1:0]         first_fail_vec,
  output logic [1:0]               first_fail_de
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam vec_t       LAST_VEC    = vec_t'(NUM_VECTORS - 1);

  state_e state_q, state_d;
  vec_t   vec_q;
  logic   timer_load, timer_zero;
  logic   abort_req, sample_hit, last_vec;

  assign abort_req  = abort && (state_q != IDLE);
  assign last_vec   = (vec_q == LAST_VEC);
  assign sample_hit = (state_q == SAMPLE) && !abort_req &&
                      ({cut.d_in, cut.e_in} != golden_de(vec_q));

  bist_settle_timer #(.W(8)) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .en       (state_q == SETTLE),
    .load_val (SETTLE_LOAD),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    unique case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY: begin
        timer_load = 1'b1;
        state_d    = SETTLE;
      end
      SETTLE:  if (timer_zero) state_d = SAMPLE;
      SAMPLE:  state_d = last_vec ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_req) state_d = IDLE;
  end

  assign busy = (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
  assign done = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q     <= '0;
      cut.a_out <= 1'b0;
      cut.b_out <= 1'b0;
      cut.c_out <= 1'b0;
      fail_cnt  <= '0;
      pass      <= 1'b0;
    end else if (abort_req) begin
      {cut.a_out, cut.b_out, cut.c_out} <= 3'b000;
      pass <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          vec_q    <= '0;
          fail_cnt <= '0;
          pass     <= 1'b0;
        end
        APPLY: {cut.a_out, cut.b_out, cut.c_out} <= vec_q;
        SAMPLE: begin
          if (sample_hit && fail_cnt != '1) fail_cnt <= fail_cnt + CNT_W'(1);
          // pass is settled on entry to DONE so it is valid alongside the done pulse.
          if (last_vec) pass <= !sample_hit && (fail_cnt == '0);
          else          vec_q <= vec_q + VEC_W'(1);
        end
        DONE: {cut.a_out, cut.b_out, cut.c_out} <= 3'b000;
        default: ;
      endcase
    end
  end

`ifdef BIST_FAIL_CAPTURE_EN
  // fail_cnt is still zero on the first mismatch of a sweep, so it doubles as the "not yet captured" flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vec <= '0;
      first_fail_de  <= '0;
    end else if (state_q == IDLE && start) begin
      first_fail_vec <= '0;
      first_fail_de  <= '0;
    end else if (sample_hit && fail_cnt == '0) begin
      first_fail_vec <= vec_q;
      first_fail_de  <= {cut.d_in, cut.e_in};
    end
  end
`else
  assign first_fail_vec = '0;
  assign first_fail_de  = '0;
`endif

endmodule

// File: tb/tb_prop_delay_bist_checker.sv
// Directed bench for prop_delay_bist_checker with a behavioural circuit under test and fault modes.
module tb_prop_delay_bist_checker;

  logic       clk, rst_n, start, abort;
  logic       busy, done, pass;
  logic [3:0] fail_cnt;
  logic [2:0] first_fail_vec;
  logic [1:0] first_fail_de;
  int         mode;      // 0: correct circuit, 1: e stuck at 0, 2: d inverted
  int         checks, errors, done_cnt;

  prop_delay_bist_if cut_if ();

  prop_delay_bist_checker #(.SETTLE_CYCLES(4), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cut            (cut_if),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_cnt       (fail_cnt),
    .first_fail_vec (first_fail_vec),
    .first_fail_de  (first_fail_de)
  );

  logic d_good, e_good;
  assign d_good = ~(cut_if.a_out & cut_if.b_out) | cut_if.c_out;
  assign e_good = cut_if.a_out & cut_if.b_out;
  assign cut_if.d_in = (mode == 2) ? ~d_good : d_good;
  assign cut_if.e_in = (mode == 1) ? 1'b0 : e_good;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  function automatic logic [2:0] abc();
    return {cut_if.a_out, cut_if.b_out, cut_if.c_out};
  endfunction

  task automatic run_sweep(input int m, input bit spam, input int exp_fail,
                           input int exp_vec, input int exp_de);
    int busy_cycles;
    int done_before;
    mode        = m;
    busy_cycles = 0;
    done_before = done_cnt;
    start = 1'b1;
    tick();
    start = spam;
    for (int i = 0; i < 48; i++) begin
      if (busy) busy_cycles++;
      if (i % 6 == 5) check("abc_step", abc(), i / 6);
      tick();
    end
    start = 1'b0;
    check("busy_len", busy_cycles, 48);
    check("busy_off_in_done", busy, 0);
    check("done_pulse", done, 1);
    check("pass", pass, (exp_fail == 0) ? 1 : 0);
    check("fail_cnt", fail_cnt, exp_fail);
`ifdef BIST_FAIL_CAPTURE_EN
    check("first_fail_vec", first_fail_vec, exp_vec);
    check("first_fail_de", first_fail_de, exp_de);
`else
    check("first_fail_vec_tied", first_fail_vec, 0);
    check("first_fail_de_tied", first_fail_de, 0);
`endif
    tick();
    check("done_one_cycle", done, 0);
    check("abc_cleared", abc(), 0);
    check("pass_held", pass, (exp_fail == 0) ? 1 : 0);
    check("done_count", done_cnt - done_before, 1);
    tick();
  endtask

  initial begin
    int done_before;
    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_cnt", fail_cnt, 0);
    check("rst_abc", abc(), 0);
    #11 rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_start", busy, 0);

    run_sweep(0, 1'b0, 0, 0, 0);   // correct circuit
    run_sweep(1, 1'b0, 2, 6, 0);   // e stuck at 0: vectors 6,7 fail; {d,e} at 6 is 00
    run_sweep(2, 1'b0, 8, 0, 0);   // d inverted: every vector fails
    run_sweep(0, 1'b1, 0, 0, 0);   // start held during the sweep

    // Abort while vec=3 is applied, after vectors 0..2 have failed.
    mode = 2;
    done_before = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("abort_pre_abc", abc(), 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_abc", abc(), 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_fail_frozen", fail_cnt, 3);
    repeat (3) tick();
    check("abort_no_done", done_cnt - done_before, 0);
    check("abort_still_idle", busy, 0);
    run_sweep(0, 1'b0, 0, 0, 0);

    // Asynchronous reset mid-SETTLE of vector 5.
    mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    check("pre_rst_abc", abc(), 5);
    check("pre_rst_fail_cnt", fail_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_abc", abc(), 0);
    check("async_rst_fail_cnt", fail_cnt, 0);
    check("async_rst_pass", pass, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ffv", first_fail_vec, 0);
    check("async_rst_ffde", first_fail_de, 0);
    #2 rst_n = 1'b1;
    done_before = done_cnt;
    repeat (4) tick();
    check("post_rst_idle", busy, 0);
    check("post_rst_abc", abc(), 0);
    check("post_rst_no_done", done_cnt - done_before, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
